// File: rtl/kyber_pkg.sv
// kyber_pkg
//   Shared constants and helpers for the Kyber NTT-domain datapath.
//   N      : coefficients per polynomial (128 degree-1 pairs)
//   Q      : modulus
//   ZETAS  : bit-reversed Kyber zeta table, zetas[i] = 17^BitRev7(i) mod Q,
//            the same table the NTT stage uses
//   state_t: FSM states of multiply_ntts
//   mod_q  : signed reduction into [0,Q)
//   add_q  : modular add of two values already in [0,Q)
package kyber_pkg;

    localparam int unsigned N = 256;
    localparam int          Q = 3329;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [11:0] ZETAS [0:127] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    // Truncating remainder keeps the dividend's sign; fold negatives up by Q.
    function automatic logic [11:0] mod_q(input logic signed [31:0] x);
        logic signed [31:0] r;
        r = x % Q;
        if (r < 0)
            r = r + Q;
        return r[11:0];
    endfunction

    function automatic logic [11:0] add_q(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 13'(Q))
            s = s - 13'(Q);
        return s[11:0];
    endfunction

endpackage

// File: rtl/base_case_mul.sv
// base_case_mul
//   Combinational Kyber BaseCaseMultiply of one degree-1 pair modulo X^2 - gamma.
//   a0,a1 : first operand pair, in [0,Q)
//   b0,b1 : second operand pair, in [0,Q)
//   gamma : twiddle for this pair, in [0,Q)
//   c0    : (a0*b0 + ((a1*b1) mod Q)*gamma) mod Q
//   c1    : (a0*b1 + a1*b0) mod Q
module base_case_mul
    import kyber_pkg::*;
(
    input  logic [11:0] a0,
    input  logic [11:0] a1,
    input  logic [11:0] b0,
    input  logic [11:0] b1,
    input  logic [11:0] gamma,
    output logic [11:0] c0,
    output logic [11:0] c1
);

    logic [23:0] p00, p11, p01, p10, pg;
    logic [11:0] r11;
    logic [24:0] s0, s1;

    always_comb begin
        p00 = 24'(a0) * 24'(b0);
        p11 = 24'(a1) * 24'(b1);
        p01 = 24'(a0) * 24'(b1);
        p10 = 24'(a1) * 24'(b0);
        // a1*b1 is reduced first so the gamma product stays within 24 bits
        r11 = mod_q(32'(p11));
        pg  = 24'(r11) * 24'(gamma);
        s0  = 25'(p00) + 25'(pg);
        s1  = 25'(p01) + 25'(p10);
        c0  = mod_q(32'(s0));
        c1  = mod_q(32'(s1));
    end

endmodule

// File: rtl/multiply_ntts.sv
// multiply_ntts
//   Pointwise NTT-domain multiplier h_hat = f_hat o g_hat, one degree-1 pair
//   per clock under a start/done handshake.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : begin a multiplication (sampled only in IDLE)
//   accumulate : (only with MULTIPLY_NTTS_ACCUM_EN) add products into h_hat
//   f_hat      : first operand, 256 signed 16-bit coefficients
//   g_hat      : second operand, 256 signed 16-bit coefficients
//   h_hat      : product, every entry in [0,Q) once done
//   done       : one-cycle pulse 130 cycles after the accepting start edge
// Optional feature macro: MULTIPLY_NTTS_ACCUM_EN
module multiply_ntts
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
`ifdef MULTIPLY_NTTS_ACCUM_EN
    input  logic               accumulate,
`endif
    input  logic signed [15:0] f_hat [0:N-1],
    input  logic signed [15:0] g_hat [0:N-1],
    output logic signed [15:0] h_hat [0:N-1],
    output logic               done
);

    state_t      state, state_nxt;
    logic [6:0]  p;
    logic [11:0] fq [0:N-1];
    logic [11:0] gq [0:N-1];
    logic [7:0]  ie, io;
    logic [11:0] zeta, gamma;
    logic [11:0] c0, c1, w0, w1;
`ifdef MULTIPLY_NTTS_ACCUM_EN
    logic        acc_q;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (p == 7'd127) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pair p uses zetas[64 + p/2]; odd pairs take the negated twiddle.
    always_comb begin
        ie    = {p, 1'b0};
        io    = {p, 1'b1};
        zeta  = ZETAS[{1'b1, p[6:1]}];
        gamma = p[0] ? (12'(Q) - zeta) : zeta;
    end

    base_case_mul u_bcm (
        .a0    (fq[ie]),
        .a1    (fq[io]),
        .b0    (gq[ie]),
        .b1    (gq[io]),
        .gamma (gamma),
        .c0    (c0),
        .c1    (c1)
    );

    always_comb begin
        w0 = c0;
        w1 = c1;
`ifdef MULTIPLY_NTTS_ACCUM_EN
        if (acc_q) begin
            w0 = add_q(h_hat[ie][11:0], c0);
            w1 = add_q(h_hat[io][11:0], c1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            p     <= '0;
            done  <= 1'b0;
`ifdef MULTIPLY_NTTS_ACCUM_EN
            acc_q <= 1'b0;
`endif
            for (int unsigned i = 0; i < N; i++) begin
                fq[i]    <= '0;
                gq[i]    <= '0;
                h_hat[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            done  <= (state == DONE);
            case (state)
                IDLE: begin
`ifdef MULTIPLY_NTTS_ACCUM_EN
                    if (start)
                        acc_q <= accumulate;
`endif
                end
                LOAD: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        fq[i] <= mod_q(32'(f_hat[i]));
                        gq[i] <= mod_q(32'(g_hat[i]));
                    end
                    p <= '0;
                end
                RUN: begin
                    h_hat[ie] <= {4'd0, w0};
                    h_hat[io] <= {4'd0, w1};
                    p         <= p + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_ntts.sv
// tb_multiply_ntts
//   Self-checking bench for multiply_ntts. The reference model works from the
//   arithmetic definition: twiddles are computed as 17^BitRev7(i) mod Q and
//   each pair is multiplied with plain integer arithmetic.
//   Honours MULTIPLY_NTTS_ACCUM_EN when defined.
module tb_multiply_ntts;

    localparam int QM = 3329;
    localparam int NN = 256;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
`ifdef MULTIPLY_NTTS_ACCUM_EN
    logic               accumulate = 1'b0;
`endif
    logic signed [15:0] f [0:NN-1];
    logic signed [15:0] g [0:NN-1];
    logic signed [15:0] h [0:NN-1];
    logic               done;

    int eh [0:NN-1];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multiply_ntts dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
`ifdef MULTIPLY_NTTS_ACCUM_EN
        .accumulate (accumulate),
`endif
        .f_hat      (f),
        .g_hat      (g),
        .h_hat      (h),
        .done       (done)
    );

    function automatic int modq(input int x);
        return ((x % QM) + QM) % QM;
    endfunction

    function automatic int bitrev7(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 7; b++)
            if ((x >> b) & 1) r = r | (1 << (6 - b));
        return r;
    endfunction

    function automatic int zeta_of(input int i);
        int r;
        r = 1;
        for (int k = 0; k < bitrev7(i); k++)
            r = (r * 17) % QM;
        return r;
    endfunction

    task automatic model(input bit acc);
        int a0, a1, b0, b1, gam, c0, c1;
        for (int pp = 0; pp < 128; pp++) begin
            a0  = modq(int'(f[2*pp]));
            a1  = modq(int'(f[2*pp+1]));
            b0  = modq(int'(g[2*pp]));
            b1  = modq(int'(g[2*pp+1]));
            gam = zeta_of(64 + pp/2);
            if (pp % 2 == 1) gam = QM - gam;
            c0  = (a0*b0 + ((a1*b1) % QM) * gam) % QM;
            c1  = (a0*b1 + a1*b0) % QM;
            if (acc) begin
                eh[2*pp]   = (eh[2*pp] + c0) % QM;
                eh[2*pp+1] = (eh[2*pp+1] + c1) % QM;
            end else begin
                eh[2*pp]   = c0;
                eh[2*pp+1] = c1;
            end
        end
    endtask

    task automatic chk(input string tag, input int idx, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic check_h(input string tag);
        for (int i = 0; i < NN; i++)
            chk(tag, i, int'(h[i]), eh[i]);
    endtask

    task automatic clear_in();
        for (int i = 0; i < NN; i++) begin
            f[i] = '0;
            g[i] = '0;
        end
    endtask

    task automatic rand_in();
        for (int i = 0; i < NN; i++) begin
            f[i] = 16'($urandom);
            g[i] = 16'($urandom);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NN; i++) eh[i] = 0;
    endtask

    // Pulses start, then waits (bounded) for done; checks latency and pulse width.
    // At cycle 'disturb' (if > 0) start is re-pulsed and the operands scrambled.
    task automatic do_run(input string tag, input int disturb);
        int lat;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            if (c == disturb) begin
                start = 1'b1;
                rand_in();
            end else if (c == disturb + 1) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 0, lat, 130);
        @(posedge clk);
        #1 chk({tag, "_done_width"}, 0, int'(done), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
    endtask

    initial begin
        int pulses;
        clear_in();
        clear_model();

        // Reset state
        #12;
        chk("reset_done", 0, int'(done), 0);
        check_h("reset_h");
        @(negedge clk);
        reset_n = 1'b1;

        // Zero operands
        model(1'b0);
        do_run("zero", 0);
        check_h("zero_h");

        // Pair 0 gamma
        clear_in();
        f[1] = 16'sd1; g[1] = 16'sd1;
        model(1'b0);
        do_run("pair0", 0);
        chk("pair0_h0", 0, int'(h[0]), 17);
        check_h("pair0_h");

        // Pair 1 gamma
        clear_in();
        f[3] = 16'sd1; g[3] = 16'sd1;
        model(1'b0);
        do_run("pair1", 0);
        chk("pair1_h2", 2, int'(h[2]), 3312);
        check_h("pair1_h");

        // Cross term
        clear_in();
        f[0] = 16'sd2; g[1] = 16'sd5;
        model(1'b0);
        do_run("cross", 0);
        chk("cross_h1", 1, int'(h[1]), 10);
        check_h("cross_h");

        // Reduction of the largest residue
        clear_in();
        f[0] = 16'sd3328; g[0] = 16'sd3328;
        model(1'b0);
        do_run("maxres", 0);
        chk("maxres_h0", 0, int'(h[0]), 1);

        // Negative input
        clear_in();
        f[0] = -16'sd1; g[0] = 16'sd2;
        model(1'b0);
        do_run("neg", 0);
        chk("neg_h0", 0, int'(h[0]), 3327);
        check_h("neg_h");

        // Random operands
        for (int r = 0; r < 3; r++) begin
            rand_in();
            model(1'b0);
            do_run("rand", 0);
            check_h("rand_h");
        end

        // start re-pulsed and inputs changed during RUN: run unaffected, nothing queued
        rand_in();
        model(1'b0);
        do_run("busy", 20);
        check_h("busy_h");
        pulses = 0;
        for (int c = 0; c < 140; c++) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        chk("busy_no_requeue", 0, pulses, 0);

        // Reset mid-run at pair 50
        rand_in();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (51) @(posedge clk);
        #1 reset_n = 1'b0;
        #2;
        clear_model();
        chk("midreset_done", 0, int'(done), 0);
        check_h("midreset_h");
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1 if (done) pulses++;
        end
        chk("midreset_no_done", 0, pulses, 0);
        check_h("midreset_h_after");
        rand_in();
        model(1'b0);
        do_run("after_reset", 0);
        check_h("after_reset_h");

`ifdef MULTIPLY_NTTS_ACCUM_EN
        // Accumulate two runs
        apply_reset();
        clear_in();
        f[0] = 16'sd1; g[0] = 16'sd1;
        accumulate = 1'b1;
        model(1'b1);
        do_run("acc1", 0);
        model(1'b1);
        do_run("acc2", 0);
        chk("acc_h0", 0, int'(h[0]), 2);
        check_h("acc_h");
        rand_in();
        model(1'b1);
        do_run("acc_rand", 0);
        check_h("acc_rand_h");
        accumulate = 1'b0;
        rand_in();
        model(1'b0);
        do_run("overwrite", 0);
        check_h("overwrite_h");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiply_ntts.md
Name: multiply_ntts

Overview:
- Pointwise multiplier in the NTT domain; sits directly downstream of the forward NTT stage.
- Takes two 256-coefficient NTT-domain polynomials (f_hat, g_hat) and produces h_hat = f_hat ∘ g_hat.
- Uses the Kyber BaseCaseMultiply over 128 degree-1 pairs, one pair per clock, under a start/done handshake.
- Its output feeds the inverse NTT stage.

Parameters:
- N, 256, number of coefficients (128 pairs).
- Q, 3329, modulus.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a multiplication; sampled only in IDLE.
- f_hat  input  signed 16 x [255:0]  first NTT-domain operand.
- g_hat  input  signed 16 x [255:0]  second NTT-domain operand.
- h_hat  output  signed 16 x [255:0]  product; every value in [0,Q) once done.
- done  output  1  one-cycle pulse when h_hat is complete.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- While reset_n = 0:
  - state = IDLE, done = 0, pair counter p = 0;
  - all h_hat entries = 0;
  - latched operand copies = 0.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - done = 0.
  - start = 1 moves to LOAD on the same edge (edge k).
- LOAD (edge k+1):
  - latch f_hat and g_hat into internal copies, reducing each coefficient to [0,Q): x mod Q, plus Q if negative;
  - p = 0; go to RUN.
- RUN (edges k+2 .. k+129): on edge k+2+p, compute pair p:
  - a0 = F[2p], a1 = F[2p+1], b0 = G[2p], b1 = G[2p+1];
  - gamma = zetas[64 + p/2] if p is even, else Q - zetas[64 + p/2];
  - h_hat[2p] = (a0*b0 + ((a1*b1) mod Q)*gamma) mod Q;
  - h_hat[2p+1] = (a0*b1 + a1*b0) mod Q;
  - p increments; after p = 127, go to DONE.
- DONE (edge k+130): done = 1 for exactly one cycle; return to IDLE.
- Latency: done is high 130 cycles after the edge that accepted start.
- h_hat holds its values until the next run writes them.
- Arithmetic widths: products are unsigned up to 24 bits; the sum in the even-index term uses a 25-bit accumulator before reduction. Outputs are always in [0,Q).
- start while in LOAD, RUN or DONE is ignored; no queueing.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.
- Input changes after LOAD do not affect the run in progress.
- Zeta table: the same 128-entry bit-reversed Kyber zeta table used by the NTT stage. zetas[64] = 17, so gamma for p = 0 is 17 and for p = 1 is 3312.

Optional Feature:
- Macro: MULTIPLY_NTTS_ACCUM_EN.
- Defined:
  - adds input port accumulate (1 bit), sampled with start;
  - when accumulate = 1, RUN writes h_hat[i] = (h_hat[i] + product_i) mod Q instead of overwriting;
  - this serves matrix-vector row sums; reset still clears h_hat.
- Undefined: no accumulate port; h_hat is always overwritten.

Decomposition:
- Shared package kyber_pkg:
  - constants N and Q;
  - the zetas table, shared with the NTT stage;
  - state_t enum for IDLE, LOAD, RUN, DONE;
  - mod_q reduction function.
- Sub-module base_case_mul: purely combinational.
  - Inputs: a0, a1, b0, b1, gamma.
  - Outputs: c0, c1, both in [0,Q).
- The top level holds the FSM, the pair counter, the operand latches and h_hat.

Test Plan:
- Zero operands: f = g = 0, pulse start -> all h_hat = 0; done pulses exactly 130 cycles after the start edge, for one cycle.
- Pair 0 gamma: f[1] = g[1] = 1, all else 0 -> h_hat[0] = 17, all other h_hat = 0.
- Pair 1 gamma: f[3] = g[3] = 1 -> h_hat[2] = 3312.
- Cross term: f[0] = 2, g[1] = 5 -> h_hat[1] = 10.
- Reduction and negative inputs: f[0] = g[0] = 3328 -> h_hat[0] = 1; f[0] = -1, g[0] = 2 -> h_hat[0] = 3327.
- Reset mid-run: drop reset_n at pair 50 -> done never pulses and h_hat = 0; a following start completes normally.
- Start ignored while busy: start re-pulsed during RUN -> no effect on the run.
- With MULTIPLY_NTTS_ACCUM_EN: two runs with accumulate = 1 and f[0] = g[0] = 1 -> h_hat[0] = 2.
